upower_lsu: RTL and testbench

- Load/store execute stage for uPower D-form memory instructions (lwz, lhz, lbz, stw, sth, stb).
- Sits directly upstream of the register file. Accepts a decoded request, computes EA = (RA|0) + EXTS(D), performs one data-memory transaction, and returns load results as a single write-back beat (rt index + data) for the register file to consume.
- Memory is big-endian: byte offset 0 is bits [31:24].

---
 rtl/upower_lsu_pkg.sv | 49 ++++
 rtl/upower_lsu_if.sv | 54 +++++
 rtl/upower_lsu_align.sv | 68 ++++++
 rtl/upower_lsu.sv | 183 ++++++++++++++++++
 tb/tb_upower_lsu.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/upower_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : upower_lsu_pkg
// Description : Shared op encodings, access sizes, FSM states and helpers
//               for the uPower D-form load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package upower_lsu_pkg;

    localparam int c_XLEN   = 32;
    localparam int c_REG_AW = 5;

    // bit2 = store, bits[1:0] = access size
    localparam logic [2:0] c_OP_LWZ = 3'b000;
    localparam logic [2:0] c_OP_LHZ = 3'b001;
    localparam logic [2:0] c_OP_LBZ = 3'b010;
    localparam logic [2:0] c_OP_STW = 3'b100;
    localparam logic [2:0] c_OP_STH = 3'b101;
    localparam logic [2:0] c_OP_STB = 3'b110;

    localparam logic [1:0] c_SZ_WORD = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        WB   = 3'd3
`ifdef UPOWER_LSU_UPDATE_EN
        ,
        WBU  = 3'd4
`endif
    } state_e;

    // Undefined encodings report as misaligned so they never reach memory.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        case (op)
            c_OP_LWZ, c_OP_STW: bad = (off != 2'b00);
            c_OP_LHZ, c_OP_STH: bad = off[0];
            c_OP_LBZ, c_OP_STB: bad = 1'b0;
            default:            bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/upower_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : upower_lsu_if
// Description : Request, data-memory and write-back signal bundle of the LSU.
//               slave = LSU view, master = surrounding pipeline/memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface upower_lsu_if
    import upower_lsu_pkg::*;
#(
    parameter int XLEN   = c_XLEN,
    parameter int REG_AW = c_REG_AW
);

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [REG_AW-1:0] req_ra_idx;
    logic [XLEN-1:0]   req_ra_val;
    logic [15:0]       req_d;
    logic [REG_AW-1:0] req_rt;
    logic [XLEN-1:0]   req_st_data;
    logic              req_update;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [3:0]        mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    logic              wb_valid;
    logic [REG_AW-1:0] wb_rt;
    logic [XLEN-1:0]   wb_data;
    logic              err_align;

    modport slave (
        input  req_valid, req_op, req_ra_idx, req_ra_val, req_d, req_rt,
               req_st_data, req_update, mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
               wb_valid, wb_rt, wb_data, err_align
    );

    modport master (
        output req_valid, req_op, req_ra_idx, req_ra_val, req_d, req_rt,
               req_st_data, req_update, mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
               wb_valid, wb_rt, wb_data, err_align
    );

endinterface
`default_nettype wire

// File: rtl/upower_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : upower_lsu_align
// Description : Big-endian byte-lane steering: byte enables, replicated store
//               data and zero-extended load extraction.
// Revision    : 1.0 - initial release
// ============================================================================
module upower_lsu_align
    import upower_lsu_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane 0 is the most significant byte.
    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'b00: w_byte = i_rdata[31:24];
            2'b01: w_byte = i_rdata[23:16];
            2'b10: w_byte = i_rdata[15:8];
            2'b11: w_byte = i_rdata[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    assign w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];

    always_comb begin
        o_be      = 4'b0000;
        o_wdata   = '0;
        o_ld_data = '0;
        case (i_size)
            c_SZ_WORD: begin
                o_be      = 4'b1111;
                o_wdata   = i_st_data;
                o_ld_data = i_rdata;
            end
            c_SZ_HALF: begin
                o_be      = i_off[1] ? 4'b0011 : 4'b1100;
                o_wdata   = {(XLEN/16){i_st_data[15:0]}};
                o_ld_data = {{(XLEN-16){1'b0}}, w_half};
            end
            c_SZ_BYTE: begin
                o_be      = 4'b1000 >> i_off;
                o_wdata   = {(XLEN/8){i_st_data[7:0]}};
                o_ld_data = {{(XLEN-8){1'b0}}, w_byte};
            end
            default: begin
                o_be      = 4'b0000;
                o_wdata   = '0;
                o_ld_data = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/upower_lsu.sv
`default_nettype none
// ============================================================================
// Module      : upower_lsu
// Description : uPower D-form load/store execute stage (lwz/lhz/lbz/stw/sth/
//               stb). Optional update forms via UPOWER_LSU_UPDATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module upower_lsu
    import upower_lsu_pkg::*;
#(
    parameter int XLEN   = c_XLEN,
    parameter int REG_AW = c_REG_AW
) (
    input  logic        clock,
    input  logic        reset,
    upower_lsu_if.slave bus
);

    state_e            r_state;
    state_e            w_state_nxt;

    logic [2:0]        r_op;
    logic [REG_AW-1:0] r_rt;
    logic [XLEN-1:0]   r_st_data;
    logic [XLEN-1:0]   r_ea;
    logic [XLEN-1:0]   r_rdata;
    logic              r_err;

    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_ea;
    logic              w_accept;
    logic              w_bad;
    logic              w_store;
    logic              w_last;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ld_data;

    assign w_base   = (bus.req_ra_idx == '0) ? '0 : bus.req_ra_val;
    assign w_ea     = w_base + {{(XLEN-16){bus.req_d[15]}}, bus.req_d};
    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_store  = r_op[2];

`ifdef UPOWER_LSU_UPDATE_EN
    logic              r_update;
    logic [REG_AW-1:0] r_ra;

    // Update forms need a real base register distinct from a load target.
    assign w_bad = is_misaligned(bus.req_op, w_ea[1:0])
                 || (bus.req_update && ((bus.req_ra_idx == '0)
                 || (!bus.req_op[2] && (bus.req_ra_idx == bus.req_rt))));
    assign w_last = !r_update;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_update <= 1'b0;
            r_ra     <= '0;
        end else if (w_accept && !w_bad) begin
            r_update <= bus.req_update;
            r_ra     <= bus.req_ra_idx;
        end
    end
`else
    logic w_unused_update;

    assign w_bad           = is_misaligned(bus.req_op, w_ea[1:0]);
    assign w_last          = 1'b1;
    assign w_unused_update = bus.req_update;
`endif

    upower_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_size    (r_op[1:0]),
        .i_off     (r_ea[1:0]),
        .i_st_data (r_st_data),
        .i_rdata   (r_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op      <= '0;
            r_rt      <= '0;
            r_st_data <= '0;
            r_ea      <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad;
            if (w_accept && !w_bad) begin
                r_op      <= bus.req_op;
                r_rt      <= bus.req_rt;
                r_st_data <= bus.req_st_data;
                r_ea      <= w_ea;
            end
            if ((r_state == WAIT) && bus.mem_rsp_valid) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every output is decoded from registered state, so the memory request
    // stays stable for as long as it is stalled.
    always_comb begin
        w_state_nxt       = r_state;
        bus.req_ready     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_be        = 4'b0000;
        bus.mem_wdata     = '0;
        bus.wb_valid      = 1'b0;
        bus.wb_rt         = '0;
        bus.wb_data       = '0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid && !w_bad) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_we        = w_store;
                bus.mem_addr      = {r_ea[XLEN-1:2], 2'b00};
                bus.mem_be        = w_be;
                bus.mem_wdata     = w_store ? w_wdata : '0;
                if (bus.mem_req_ready) begin
                    if (!w_store) begin
                        w_state_nxt = WAIT;
                    end else begin
`ifdef UPOWER_LSU_UPDATE_EN
                        w_state_nxt = w_last ? IDLE : WBU;
`else
                        w_state_nxt = IDLE;
`endif
                    end
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    w_state_nxt = WB;
                end
            end
            WB: begin
                bus.wb_valid = 1'b1;
                bus.wb_rt    = r_rt;
                bus.wb_data  = w_ld_data;
`ifdef UPOWER_LSU_UPDATE_EN
                w_state_nxt  = w_last ? IDLE : WBU;
`else
                w_state_nxt  = IDLE;
`endif
            end
`ifdef UPOWER_LSU_UPDATE_EN
            WBU: begin
                bus.wb_valid = 1'b1;
                bus.wb_rt    = r_ra;
                bus.wb_data  = r_ea;
                w_state_nxt  = IDLE;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.err_align = r_err;

endmodule
`default_nettype wire

// File: tb/tb_upower_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_upower_lsu
// Description : Directed self-checking bench for upower_lsu; update-form
//               vectors are active when UPOWER_LSU_UPDATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upower_lsu;
    import upower_lsu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    upower_lsu_if bus ();

    upower_lsu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req_ready"},     32'(bus.req_ready),     32'd1);
        check({tag, ".mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({tag, ".mem_we"},        32'(bus.mem_we),        32'd0);
        check({tag, ".mem_addr"},      bus.mem_addr,           32'd0);
        check({tag, ".mem_be"},        32'(bus.mem_be),        32'd0);
        check({tag, ".mem_wdata"},     bus.mem_wdata,          32'd0);
        check({tag, ".wb_valid"},      32'(bus.wb_valid),      32'd0);
        check({tag, ".wb_rt"},         32'(bus.wb_rt),         32'd0);
        check({tag, ".wb_data"},       bus.wb_data,            32'd0);
        check({tag, ".err_align"},     32'(bus.err_align),     32'd0);
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [4:0] ra_idx,
                         input logic [31:0] ra_val, input logic [15:0] d, input logic [4:0] rt,
                         input logic [31:0] st, input logic upd);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_ra_idx  = ra_idx;
        bus.req_ra_val  = ra_val;
        bus.req_d       = d;
        bus.req_rt      = rt;
        bus.req_st_data = st;
        bus.req_update  = upd;
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid  = 1'b0;
        bus.req_update = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] op, input logic [4:0] ra_idx,
                           input logic [31:0] ra_val, input logic [15:0] d, input logic [4:0] rt,
                           input logic upd, input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        bus.mem_req_ready = 1'b1;
        issue(tag, op, ra_idx, ra_val, d, rt, 32'hFFFF_FFFF, upd);
        check({tag, ".mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
        check({tag, ".mem_we"},        32'(bus.mem_we),        32'd0);
        check({tag, ".mem_addr"},      bus.mem_addr,           exp_addr);
        check({tag, ".mem_be"},        32'(bus.mem_be),        32'(exp_be));
        // a response in the handshake cycle must be ignored
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = ~rdata;
        tick();
        check({tag, ".wait_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({tag, ".wait_wb_valid"},  32'(bus.wb_valid),      32'd0);
        bus.mem_rdata = rdata;
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'h0;
        check({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'd1);
        check({tag, ".wb_rt"},    32'(bus.wb_rt),    32'(rt));
        check({tag, ".wb_data"},  bus.wb_data,       exp_data);
        tick();
        check({tag, ".wb_done"},    32'(bus.wb_valid),  32'd0);
        check({tag, ".ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_store(input string tag, input logic [2:0] op, input logic [4:0] ra_idx,
                            input logic [31:0] ra_val, input logic [15:0] d, input logic [31:0] rs,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        bus.mem_req_ready = 1'b1;
        issue(tag, op, ra_idx, ra_val, d, 5'd1, rs, 1'b0);
        check({tag, ".mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
        check({tag, ".mem_we"},        32'(bus.mem_we),        32'd1);
        check({tag, ".mem_addr"},      bus.mem_addr,           exp_addr);
        check({tag, ".mem_be"},        32'(bus.mem_be),        32'(exp_be));
        check({tag, ".mem_wdata"},     bus.mem_wdata,          exp_wdata);
        check({tag, ".hs_wb_valid"},   32'(bus.wb_valid),      32'd0);
        tick();
        check({tag, ".ready_back"},    32'(bus.req_ready),     32'd1);
        check({tag, ".req_dropped"},   32'(bus.mem_req_valid), 32'd0);
        check({tag, ".no_wb"},         32'(bus.wb_valid),      32'd0);
    endtask

    task automatic do_bad(input string tag, input logic [2:0] op, input logic [4:0] ra_idx,
                          input logic [31:0] ra_val, input logic [15:0] d, input logic [4:0] rt,
                          input logic upd);
        bus.mem_req_ready = 1'b1;
        issue(tag, op, ra_idx, ra_val, d, rt, 32'h0, upd);
        check({tag, ".err_align"},     32'(bus.err_align),     32'd1);
        check({tag, ".mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({tag, ".req_ready"},     32'(bus.req_ready),     32'd1);
        tick();
        check({tag, ".err_cleared"},   32'(bus.err_align),     32'd0);
        check({tag, ".no_mem"},        32'(bus.mem_req_valid), 32'd0);
        check({tag, ".no_wb"},         32'(bus.wb_valid),      32'd0);
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_op        = 3'b000;
        bus.req_ra_idx    = 5'd0;
        bus.req_ra_val    = 32'h0;
        bus.req_d         = 16'h0;
        bus.req_rt        = 5'd0;
        bus.req_st_data   = 32'h0;
        bus.req_update    = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'h0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");

        do_load("lwz",      c_OP_LWZ, 5'd1, 32'h0000_0100, 16'h0008, 5'd7, 1'b0,
                32'hDEAD_BEEF, 32'h0000_0108, 4'b1111, 32'hDEAD_BEEF);
        do_load("lbz_ra0",  c_OP_LBZ, 5'd0, 32'h5555_0000, 16'h0003, 5'd4, 1'b0,
                32'h1122_3344, 32'h0000_0000, 4'b0001, 32'h0000_0044);
        do_load("lbz_wrap", c_OP_LBZ, 5'd2, 32'hFFFF_FFFC, 16'h0005, 5'd8, 1'b0,
                32'h1122_3344, 32'h0000_0000, 4'b0100, 32'h0000_0022);
        do_load("lhz_hi",   c_OP_LHZ, 5'd5, 32'h0000_0300, 16'h0000, 5'd9, 1'b0,
                32'hCAFE_F00D, 32'h0000_0300, 4'b1100, 32'h0000_CAFE);
        do_load("lhz_lo",   c_OP_LHZ, 5'd5, 32'h0000_0306, 16'hFFFC, 5'd10, 1'b0,
                32'hCAFE_F00D, 32'h0000_0300, 4'b0011, 32'h0000_F00D);

        do_store("sth", c_OP_STH, 5'd2, 32'h0000_0204, 16'hFFFE, 32'h0000_ABCD,
                 32'h0000_0200, 4'b0011, 32'hABCD_ABCD);
        do_store("stb", c_OP_STB, 5'd3, 32'h0000_0010, 16'h0002, 32'h1234_565A,
                 32'h0000_0010, 4'b0010, 32'h5A5A_5A5A);
        do_store("stw", c_OP_STW, 5'd0, 32'hAAAA_AAAA, 16'h7FFC, 32'h0123_4567,
                 32'h0000_7FFC, 4'b1111, 32'h0123_4567);

        do_bad("lwz_mis",  c_OP_LWZ, 5'd1, 32'h0000_0100, 16'h0005, 5'd2, 1'b0);
        do_bad("lhz_mis",  c_OP_LHZ, 5'd1, 32'h0000_0200, 16'h0001, 5'd2, 1'b0);
        do_bad("sth_mis",  c_OP_STH, 5'd0, 32'h0000_0000, 16'h0003, 5'd2, 1'b0);
        do_bad("op_undef", 3'b011,   5'd0, 32'h0000_0000, 16'h0000, 5'd2, 1'b0);

        // stalled LHZ, then reset while waiting for the response
        bus.mem_req_ready = 1'b0;
        issue("stall", c_OP_LHZ, 5'd1, 32'h0000_0300, 16'h0002, 5'd6, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall.mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
            check("stall.mem_addr",      bus.mem_addr,           32'h0000_0300);
            check("stall.mem_be",        32'(bus.mem_be),        32'(4'b0011));
            check("stall.mem_we",        32'(bus.mem_we),        32'd0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        check("stall.release_valid", 32'(bus.mem_req_valid), 32'd1);
        check("stall.release_addr",  bus.mem_addr,           32'h0000_0300);
        tick();
        check("stall.in_wait", 32'(bus.mem_req_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst_wait");
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h7777_8888;
        tick();
        bus.mem_rsp_valid = 1'b0;
        check("late_rsp.wb_valid", 32'(bus.wb_valid), 32'd0);
        tick();
        check("late_rsp.wb_valid2", 32'(bus.wb_valid),  32'd0);
        check("late_rsp.ready",     32'(bus.req_ready), 32'd1);

`ifdef UPOWER_LSU_UPDATE_EN
        bus.mem_req_ready = 1'b1;
        issue("lwzu", c_OP_LWZ, 5'd3, 32'h0000_0040, 16'h0004, 5'd9, 32'h0, 1'b1);
        check("lwzu.mem_addr", bus.mem_addr, 32'h0000_0044);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0BAD_F00D;
        tick();
        bus.mem_rsp_valid = 1'b0;
        check("lwzu.data_valid", 32'(bus.wb_valid), 32'd1);
        check("lwzu.data_rt",    32'(bus.wb_rt),    32'd9);
        check("lwzu.data",       bus.wb_data,       32'h0BAD_F00D);
        tick();
        check("lwzu.upd_valid", 32'(bus.wb_valid), 32'd1);
        check("lwzu.upd_rt",    32'(bus.wb_rt),    32'd3);
        check("lwzu.upd_data",  bus.wb_data,       32'h0000_0044);
        tick();
        check("lwzu.done",  32'(bus.wb_valid),  32'd0);
        check("lwzu.ready", 32'(bus.req_ready), 32'd1);
        do_bad("lwzu_ra_rt", c_OP_LWZ, 5'd3, 32'h0000_0040, 16'h0004, 5'd3, 1'b1);
        do_bad("lwzu_ra0",   c_OP_LWZ, 5'd0, 32'h0000_0000, 16'h0004, 5'd5, 1'b1);
`else
        do_load("upd_ignored", c_OP_LWZ, 5'd3, 32'h0000_0040, 16'h0004, 5'd9, 1'b1,
                32'h0BAD_F00D, 32'h0000_0044, 4'b1111, 32'h0BAD_F00D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
